// File: rtl/switch_alloc.sv
// rtl/switch_alloc.sv - round-robin switch/output-VC allocator with per-port credit tracking
module switch_alloc #(
    parameter int N_IN       = 5,
    parameter int N_OUT      = 5,
    parameter int FLIT_SIZE  = 16,
    parameter int HEADER_LEN = 2,
    parameter int ROUTE_LEN  = 3,
    parameter int CREDIT_MAX = 4,
    parameter logic [HEADER_LEN-1:0] TAIL_FLIT   = HEADER_LEN'(2),
    parameter logic [HEADER_LEN-1:0] SINGLE_FLIT = HEADER_LEN'(3)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_IN-1:0]              vc_wait_ovc,
    input  logic [N_IN-1:0]              vc_valid,
    input  logic [N_IN*ROUTE_LEN-1:0]    vc_route,
    input  logic [N_IN*FLIT_SIZE-1:0]    vc_flit,
    output logic [N_IN-1:0]              vc_grant,
    output logic [N_IN-1:0]              vc_credit,
    output logic [N_OUT*FLIT_SIZE-1:0]   out_flit,
    output logic [N_OUT-1:0]             out_valid,
    input  logic [N_OUT-1:0]             credit_return,
    output logic                         credit_err
);

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CW = $clog2(CREDIT_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CREDIT_MAX);

    // Per-port lock, owner, downstream credit count and round-robin pointer
    logic [N_OUT-1:0]     lock_v;
    logic [IW-1:0]        lock_own [N_OUT];
    logic [CW-1:0]        cnt      [N_OUT];
    logic [IW-1:0]        rr       [N_OUT];

    logic [ROUTE_LEN-1:0] route    [N_IN];
    logic [FLIT_SIZE-1:0] flit     [N_IN];
    logic [N_OUT-1:0]     gnt_any;
    logic [IW-1:0]        gnt_idx  [N_OUT];
    logic [N_OUT-1:0]     dep;
    logic [FLIT_SIZE-1:0] dep_flit [N_OUT];
    logic [N_OUT-1:0]     dep_last;

    // Input index k positions after base, wrapping at N_IN (base is always < N_IN)
    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_IN) s = s - N_IN;
        return IW'(s);
    endfunction

    // Split the flattened per-VC route and flit buses
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            route[i] = vc_route[i*ROUTE_LEN +: ROUTE_LEN];
            flit[i]  = vc_flit[i*FLIT_SIZE +: FLIT_SIZE];
        end
    end

    // Allocation: each free port picks the first waiting input at or after rr[p]
    always_comb begin
        logic found;
        logic [IW-1:0] cand;
        found = 1'b0;
        cand  = '0;
        for (int p = 0; p < N_OUT; p++) begin
            gnt_any[p] = 1'b0;
            gnt_idx[p] = '0;
            found      = 1'b0;
            for (int k = 0; k < N_IN; k++) begin
                cand = rr_index(rr[p], k);
                if (!lock_v[p] && !found && vc_wait_ovc[cand] && route[cand] == ROUTE_LEN'(p)) begin
                    found      = 1'b1;
                    gnt_any[p] = 1'b1;
                    gnt_idx[p] = cand;
                end
            end
        end
    end

    // Fan the per-port winners back onto the per-input grant strobes
    always_comb begin
        vc_grant = '0;
        for (int p = 0; p < N_OUT; p++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (gnt_any[p] && gnt_idx[p] == IW'(i)) vc_grant[i] = !rst;
            end
        end
    end

    // Departure: the lock owner still routed here moves a flit while credits remain
    always_comb begin
        vc_credit = '0;
        for (int p = 0; p < N_OUT; p++) begin
            dep[p]      = 1'b0;
            dep_flit[p] = '0;
            for (int i = 0; i < N_IN; i++) begin
                if (lock_v[p] && lock_own[p] == IW'(i) && cnt[p] != '0 &&
                    vc_valid[i] && route[i] == ROUTE_LEN'(p)) begin
                    dep[p]       = 1'b1;
                    dep_flit[p]  = flit[i];
                    vc_credit[i] = !rst;
                end
            end
            dep_last[p] = (dep_flit[p][FLIT_SIZE-1 -: HEADER_LEN] == TAIL_FLIT) ||
                          (dep_flit[p][FLIT_SIZE-1 -: HEADER_LEN] == SINGLE_FLIT);
        end
    end

    // Port state, output registers and credit accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_v     <= '0;
            out_valid  <= '0;
            out_flit   <= '0;
            credit_err <= 1'b0;
            for (int p = 0; p < N_OUT; p++) begin
                lock_own[p] <= '0;
                cnt[p]      <= CNT_MAX;
                rr[p]       <= '0;
            end
        end else begin
            for (int p = 0; p < N_OUT; p++) begin
                out_valid[p] <= dep[p];
                if (dep[p]) begin
                    out_flit[p*FLIT_SIZE +: FLIT_SIZE] <= dep_flit[p];
                    // A released port is only seen as free by allocation next cycle
                    if (dep_last[p]) lock_v[p] <= 1'b0;
                end else if (gnt_any[p]) begin
                    lock_v[p]   <= 1'b1;
                    lock_own[p] <= gnt_idx[p];
                    rr[p]       <= rr_index(gnt_idx[p], 1);
                end
                case ({dep[p], credit_return[p]})
                    2'b10: cnt[p] <= cnt[p] - CW'(1);
                    2'b01: begin
                        if (cnt[p] == CNT_MAX) credit_err <= 1'b1;
                        else cnt[p] <= cnt[p] + CW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/switch_alloc.md
# switch_alloc

Per-router switch and output-VC allocator sitting directly downstream of the input VCs. It grants a free output port to one waiting head/single flit per port, round-robin. It then holds that port for the packet and issues per-cycle credit strobes (the VC's `C` input) while downstream buffer credits remain. Departing flits are registered onto the output ports, and the port lock is released on the tail/single flit.

## Interface
- `N_IN`, 5: number of input VCs served
- `N_OUT`, 5: number of output ports; valid route values are 0..N_OUT-1
- `FLIT_SIZE`, from para.sv: flit width; top `HEADER_LEN` bits hold the flit type (`HEAD_FLIT`, `TAIL_FLIT`, `SINGLE_FLIT`, body)
- `ROUTE_LEN`, from para.sv: route field width
- `CREDIT_MAX`, `VC_SIZE`: downstream buffer depth per output port; counter width is $clog2(CREDIT_MAX+1)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `vc_wait_ovc`  in  N_IN  input VC i is in WAITING_FOR_OVC (G==2)
- `vc_valid`  in  N_IN  VC i `valid_out`
- `vc_route`  in  N_IN*ROUTE_LEN  VC i `R`, slice i
- `vc_flit`  in  N_IN*FLIT_SIZE  VC i `flit_out`, slice i
- `vc_grant`  out  N_IN  one-cycle OVC grant to VC i (drives VC `grant`)
- `vc_credit`  out  N_IN  flit of VC i departs this cycle (drives VC `C`)
- `out_flit`  out  N_OUT*FLIT_SIZE  registered flit per port
- `out_valid`  out  N_OUT  registered valid per port
- `credit_return`  in  N_OUT  downstream freed one slot on port p
- `credit_err`  out  1  sticky; credit_return seen with counter already at CREDIT_MAX

## Operation
- Per-port state: `lock_v[p]`, `lock_own[p]` (input index), `cnt[p]`, `rr[p]` (next-priority pointer).
- Allocation (combinational from registered state): for each port p with `lock_v[p]==0`, candidates are inputs i with `vc_wait_ovc[i]` and `vc_route[i]==p`. Pick the first candidate searching from `rr[p]` upward with wrap. Assert `vc_grant[i]`.
- On the grant edge: set `lock_v[p]=1`, `lock_own[p]=i`, and `rr[p]=(i+1) mod N_IN`.
- Each input routes to one port, so at most one grant per input per cycle. Routes >= N_OUT are never granted.
- Credit strobe: `vc_credit[i] = lock_v[p] && lock_own[p]==i && cnt[p]!=0 && vc_valid[i]`, where p = `vc_route[i]`. The strobe is combinational.
- On a strobe edge: `out_flit[p] <= vc_flit[i]` and `out_valid[p] <= 1`. Otherwise `out_valid[p] <= 0` and `out_flit` holds.
- Counter update per port:
  - departure only: `cnt` decrements by 1;
  - `credit_return` only: increments by 1;
  - both in the same cycle: unchanged;
  - `credit_return` at CREDIT_MAX with no departure: `cnt` holds and `credit_err` sets (sticky until reset).
- Release: when the departing flit's type is `TAIL_FLIT` or `SINGLE_FLIT`, clear `lock_v[p]` at that edge. The port is not re-granted in that same cycle; it becomes grantable next cycle.
- A locked port with `cnt==0` stalls: strobe held low, lock kept.

## Timing
- Reset values:
  - `vc_grant=0`, `vc_credit=0`, `out_valid=0`, `out_flit=0`, `credit_err=0`;
  - all `lock_v=0`, `cnt=CREDIT_MAX`, `rr=0`.
- Reset mid-packet drops all locks and restores credits; the upstream VCs are reset by the same `rst`.
- Grant latency: `vc_grant` rises in the same cycle `vc_wait_ovc` is seen, if the port is free. The earliest strobe for that VC is the next cycle, after the VC enters ACTIVE.
- Flit latency: strobe cycle N puts the flit on `out_flit`/`out_valid` at cycle N+1.
- Credit latency: `credit_return` at cycle N is usable for a strobe at cycle N+1.
- Throughput: one flit per port per cycle while `cnt>0`.
- Minimum port turnaround: tail at cycle N, next grant at N+1, its first flit at N+2.

## Test plan
- **Single-flit packet:** after reset, VC0 sets wait_ovc with route 2 and a SINGLE flit.
  - Cycle 0: grant[0]=1.
  - Cycle 1: credit[0]=1.
  - Cycle 2: out_valid[2]=1 with that flit, cnt[2]=CREDIT_MAX-1, lock_v[2]=0.
- **Contention round-robin:** VC1 and VC3 both wait on port 0, rr=0.
  - VC1 is granted first; its 3-flit packet completes.
  - VC3 is granted the cycle after VC1's tail; rr[0] becomes 4.
- **Credit exhaustion:** CREDIT_MAX=4, 6-flit packet, no returns.
  - Exactly 4 strobes, then credit low with the lock held.
  - One credit_return brings a strobe the next cycle.
- **Simultaneous departure and return:** cnt=2 with credit_return each cycle during a streaming body → cnt stays 2 and a flit goes out every cycle.
- **Overflow:** credit_return with cnt=CREDIT_MAX and no departure → cnt unchanged and credit_err=1, held until rst.
- **Mid-packet reset:** rst pulsed after 2 of 4 flits → next cycle every output is at its reset value and cnt=CREDIT_MAX.
